// File: rtl/bm_if_pkg.sv
// rtl/bm_if_pkg.sv - shared widths and constant helpers for the bm_if blocks
package bm_if_pkg;
   localparam int WIDTH_DEF = 2;
   localparam int CNT_W_DEF = 4;
   localparam int MAX_W     = 64;

   // Low w bits set; callers cast the result down to their own width.
   function automatic logic [MAX_W-1:0] ones_mask(input int w);
      if (w >= MAX_W) return '1;
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [MAX_W-1:0] zero_mask();
      return '0;
   endfunction
endpackage

// File: rtl/bm_if_decode.sv
// rtl/bm_if_decode.sv - value-selected hold registers and their combined decode
import bm_if_pkg::*;

module bm_if_decode #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a_in,
   output logic [WIDTH-1:0] dec_q
);
   localparam logic [WIDTH-1:0] ONES = WIDTH'(ones_mask(WIDTH));
   localparam logic [WIDTH-1:0] ZERO = WIDTH'(zero_mask());

   logic [WIDTH-1:0] hold_z;
   logic [WIDTH-1:0] hold_nz;

   // dec_q sees the hold values from before this edge, adding one stage of latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_z  <= ZERO;
         hold_nz <= ZERO;
         dec_q   <= ZERO;
      end else begin
         if (in_valid) begin
            if (a_in == ZERO) begin
               hold_z <= ONES;
            end else begin
               hold_nz <= ~a_in;
            end
         end
         dec_q <= hold_nz & hold_z;
      end
   end
endmodule

// File: rtl/bm_if_reset_pipe.sv
// rtl/bm_if_reset_pipe.sv - conditional-clear AND stage, decode path, valid chain
// and saturating clear-event counter
import bm_if_pkg::*;

module bm_if_reset_pipe #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   input  logic             d_in,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] out0,
   output logic             out1,
   output logic [WIDTH-1:0] out2,
   output logic             out01_valid,
   output logic             out2_valid,
   output logic [CNT_W-1:0] clr_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ones_mask(CNT_W));

   logic [WIDTH-1:0] dec_q;
   logic             v1;

   bm_if_decode #(.WIDTH(WIDTH)) u_decode (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .a_in     (a_in),
      .dec_q    (dec_q)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out0        <= '0;
         out1        <= 1'b0;
         out01_valid <= 1'b0;
      end else begin
         if (in_valid) begin
            if (c_in) begin
               out0 <= a_in & b_in;
               out1 <= c_in & d_in;
            end else begin
               out0 <= '0;
               out1 <= 1'b0;
            end
         end
         out01_valid <= in_valid;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out2       <= '0;
         v1         <= 1'b0;
         out2_valid <= 1'b0;
      end else begin
         out2       <= dec_q;
         v1         <= in_valid;
         out2_valid <= v1;
      end
   end

   // Clear wins over a same-edge increment; the count sticks at its maximum.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clr_cnt <= '0;
      end else if (cnt_clr) begin
         clr_cnt <= '0;
      end else if (in_valid && !c_in && (clr_cnt != CNT_MAX)) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_bm_if_reset_pipe.sv
// tb/tb_bm_if_reset_pipe.sv - directed bench with a behavioural reference model
module tb_bm_if_reset_pipe;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [1:0] a_in = 2'b00;
   logic [1:0] b_in = 2'b00;
   logic       c_in = 1'b0;
   logic       d_in = 1'b0;
   logic       cnt_clr = 1'b0;
   logic [7:0] a8 = 8'h00;
   logic [7:0] b8 = 8'h00;

   logic [1:0] out0, out2, clr_cnt;
   logic       out1, out01_valid, out2_valid;
   logic [7:0] w_out0, w_out2;
   logic       w_out1, w_out01_valid, w_out2_valid;
   logic [3:0] w_clr_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   bm_if_reset_pipe #(.WIDTH(2), .CNT_W(2)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
      .c_in(c_in), .d_in(d_in), .cnt_clr(cnt_clr), .out0(out0), .out1(out1),
      .out2(out2), .out01_valid(out01_valid), .out2_valid(out2_valid), .clr_cnt(clr_cnt)
   );

   bm_if_reset_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .a_in(a8), .b_in(b8),
      .c_in(c_in), .d_in(d_in), .cnt_clr(cnt_clr), .out0(w_out0), .out1(w_out1),
      .out2(w_out2), .out01_valid(w_out01_valid), .out2_valid(w_out2_valid), .clr_cnt(w_clr_cnt)
   );

   // Reference model: remembers whether a zero sample has been seen and the
   // complement of the latest nonzero sample, then delays their AND twice.
   logic       m_zero_seen = 1'b0;
   logic [1:0] m_nz_inv = 2'b00;
   logic [1:0] m_dec = 2'b00;
   logic [1:0] m_out2 = 2'b00;
   logic [1:0] m_out0 = 2'b00;
   logic       m_out1 = 1'b0;
   logic [2:0] m_vpipe = 3'b000;
   int         m_cnt = 0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_zero_seen <= 1'b0;
         m_nz_inv    <= 2'b00;
         m_dec       <= 2'b00;
         m_out2      <= 2'b00;
         m_out0      <= 2'b00;
         m_out1      <= 1'b0;
         m_vpipe     <= 3'b000;
         m_cnt       <= 0;
      end else begin
         if (in_valid) begin
            m_out0 <= c_in ? (a_in & b_in) : 2'b00;
            m_out1 <= c_in ? d_in : 1'b0;
            if (a_in == 2'b00) m_zero_seen <= 1'b1;
            else               m_nz_inv    <= ~a_in;
         end
         m_dec   <= (m_zero_seen ? 2'b11 : 2'b00) & m_nz_inv;
         m_out2  <= m_dec;
         m_vpipe <= {m_vpipe[1:0], in_valid};
         if (cnt_clr)                m_cnt <= 0;
         else if (in_valid && !c_in) m_cnt <= (m_cnt < 3) ? m_cnt + 1 : 3;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      check("model_out0", 64'(out0), 64'(m_out0));
      check("model_out1", 64'(out1), 64'(m_out1));
      check("model_out2", 64'(out2), 64'(m_out2));
      check("model_v01", 64'(out01_valid), 64'(m_vpipe[0]));
      check("model_v2", 64'(out2_valid), 64'(m_vpipe[1]));
      check("model_cnt", 64'(clr_cnt), 64'(m_cnt));
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b,
                        input logic c, input logic d, input logic clr);
      in_valid = v;
      a_in     = a;
      b_in     = b;
      c_in     = c;
      d_in     = d;
      cnt_clr  = clr;
   endtask

   initial begin
      tick();
      tick();
      check("rst_out0", 64'(out0), 64'h0);
      check("rst_cnt", 64'(clr_cnt), 64'h0);
      reset = 1'b0;
      tick();
      tick();
      check("idle_out2", 64'(out2), 64'h0);
      check("idle_v01", 64'(out01_valid), 64'h0);

      drive(1'b1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b0);
      tick();
      check("clr1_out0", 64'(out0), 64'h1);
      check("clr1_out1", 64'(out1), 64'h1);
      check("clr1_v01", 64'(out01_valid), 64'h1);
      drive(1'b1, 2'b10, 2'b11, 1'b0, 1'b1, 1'b0);
      tick();
      check("clr0_out0", 64'(out0), 64'h0);
      check("clr0_out1", 64'(out1), 64'h0);
      check("clr0_cnt", 64'(clr_cnt), 64'h1);

      drive(1'b1, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0);
      #3 reset = 1'b1;
      #1;
      check("async_out0", 64'(out0), 64'h0);
      check("async_v01", 64'(out01_valid), 64'h0);
      check("async_v2", 64'(out2_valid), 64'h0);
      check("async_cnt", 64'(clr_cnt), 64'h0);
      tick();
      reset = 1'b0;
      drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check("post_rst_out0", 64'(out0), 64'h0);
      check("post_rst_out2", 64'(out2), 64'h0);

      drive(1'b1, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      check("dec_e1", 64'(dut.u_decode.dec_q), 64'h0);
      check("dec_v2_e1", 64'(out2_valid), 64'h1);
      drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
      check("dec_e2", 64'(dut.u_decode.dec_q), 64'h2);
      check("out2_e2", 64'(out2), 64'h0);
      check("dec_v2_e2", 64'(out2_valid), 64'h1);
      tick();
      check("out2_e3", 64'(out2), 64'h2);
      check("dec_v2_e3", 64'(out2_valid), 64'h0);
      tick();
      check("hold_out2", 64'(out2), 64'h2);
      check("hold_out0", 64'(out0), 64'h1);
      check("hold_out1", 64'(out1), 64'h0);
      check("hold_v01", 64'(out01_valid), 64'h0);

      drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         logic [1:0] want;
         want = (i < 3) ? 2'(i + 1) : 2'd3;
         drive(1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
         tick();
         check($sformatf("cnt_step%0d", i), 64'(clr_cnt), 64'(want));
      end
      drive(1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1);
      tick();
      check("cnt_clr_prio", 64'(clr_cnt), 64'h0);

      drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_valid = 1'b1;
      a8 = 8'h00;
      tick();
      a8 = 8'h5A;
      tick();
      in_valid = 1'b0;
      a8 = 8'h00;
      tick();
      check("w8_dec", 64'(dut8.u_decode.dec_q), 64'hA5);
      tick();
      check("w8_out2", 64'(w_out2), 64'hA5);
      tick();
      check("w8_out2_hold", 64'(w_out2), 64'hA5);

      @(negedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
